// File: rtl/riscv_pkg.sv
// Shared RV32-subset encodings: opcodes, ALU operations, memory-access kinds
// and the packed control bundle produced by the decode stage.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [1:0] mem_ctrl;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  // Returns {supported, alu_op} for an ALU funct3; 011 (SLTU) is not supported.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return {1'b1, ALU_ADD};
      3'b001:  return {1'b1, ALU_SLL};
      3'b010:  return {1'b1, ALU_SLT};
      3'b100:  return {1'b1, ALU_XOR};
      3'b101:  return {1'b1, ALU_SRL};
      3'b110:  return {1'b1, ALU_OR};
      3'b111:  return {1'b1, ALU_AND};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 2R1W 32x32 register file: x0 hardwired to zero, same-cycle write-through
// bypass on both read ports, asynchronous active-low clear.
module reg_file
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_valid;

  assign wr_valid = we && (wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (wr_valid) begin
      mem[wa] <= wd;
    end
  end

  // x0 reads zero; a pending writeback to the read address wins over the array.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (ra1 == '0)                  rd1 = '0;
    else if (wr_valid && wa == ra1) rd1 = wd;
    if (ra2 == '0)                  rd2 = '0;
    else if (wr_valid && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register file, main/ALU decode, immediate
// generation, load-use stall detection and a sticky illegal-instruction flag.
module id_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic        RegWriteW,
  input  logic [4:0]  A3_W,
  input  logic [31:0] ResultW,
  input  logic [1:0]  MEM_CtrlE,
  input  logic [4:0]  A3E,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [4:0]  A3D,
  output logic [31:0] SignImmD,
  output logic [2:0]  funct3D,
  output logic        RegWriteD,
  output logic        ALUSrcD,
  output logic [1:0]  MEM_CtrlD,
  output logic [2:0]  ALUControlD,
  output logic        StallD,
  output logic        IllegalD
);

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] i_imm, s_imm;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [3:0]      alu_lu;

  ctrl_t           ctrl_raw;
  ctrl_t           ctrl_out;
  logic            decode_ok;
  logic            use_rs1, use_rs2;
  logic [XLEN-1:0] imm;
  logic [4:0]      a3;
  logic            stall_c;
  logic            illegal_q;

  assign opcode = InstrD[6:0];
  assign rd     = InstrD[11:7];
  assign f3     = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign f7     = InstrD[31:25];
  assign i_imm  = {{20{InstrD[31]}}, InstrD[31:20]};
  assign s_imm  = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign alu_lu = alu_from_funct3(f3);

  reg_file u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .we    (RegWriteW),
    .wa    (A3_W),
    .wd    (ResultW),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // Main decode; operand fields pass through even when the funct fields are bad.
  always_comb begin
    ctrl_raw  = '0;
    decode_ok = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    imm       = '0;
    a3        = '0;
    case (opcode)
      OP_R: begin
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
        a3                 = rd;
        ctrl_raw.reg_write = 1'b1;
        if (f3 == 3'b000 && f7 == F7_ALT) begin
          decode_ok         = 1'b1;
          ctrl_raw.alu_ctrl = ALU_SUB;
        end else begin
          decode_ok         = alu_lu[3] && (f7 == F7_ZERO);
          ctrl_raw.alu_ctrl = alu_lu[2:0];
        end
      end
      OP_I: begin
        use_rs1            = 1'b1;
        a3                 = rd;
        imm                = i_imm;
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.alu_src   = 1'b1;
        ctrl_raw.alu_ctrl  = alu_lu[2:0];
        decode_ok          = alu_lu[3] && !((f3 == 3'b001 || f3 == 3'b101) && f7 != F7_ZERO);
      end
      OP_LOAD: begin
        use_rs1            = 1'b1;
        a3                 = rd;
        imm                = i_imm;
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.alu_src   = 1'b1;
        ctrl_raw.mem_ctrl  = MEM_LOAD;
        ctrl_raw.alu_ctrl  = ALU_ADD;
        decode_ok          = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
        imm               = s_imm;
        ctrl_raw.alu_src  = 1'b1;
        ctrl_raw.mem_ctrl = MEM_STORE;
        ctrl_raw.alu_ctrl = ALU_ADD;
        decode_ok         = f3 inside {3'b000, 3'b001, 3'b010};
      end
      default: decode_ok = (InstrD == '0);
    endcase
  end

  assign stall_c = (MEM_CtrlE == MEM_LOAD) && (A3E != '0) &&
                   ((use_rs1 && A3E == rs1) || (use_rs2 && A3E == rs2));

  // Controls become a bubble on reset, stall or any malformed instruction.
  assign ctrl_out    = (rst_n && decode_ok && !stall_c) ? ctrl_raw : '0;
  assign RegWriteD   = ctrl_out.reg_write;
  assign ALUSrcD     = ctrl_out.alu_src;
  assign MEM_CtrlD   = ctrl_out.mem_ctrl;
  assign ALUControlD = ctrl_out.alu_ctrl;
  assign StallD      = rst_n && stall_c;
  assign RD1D        = rst_n ? rf_rd1 : '0;
  assign RD2D        = rst_n ? rf_rd2 : '0;
  assign A3D         = rst_n ? a3 : '0;
  assign SignImmD    = rst_n ? imm : '0;
  assign funct3D     = rst_n ? f3 : '0;

  // Sticky flag; an instruction held by a stall is judged once it issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       illegal_q <= 1'b0;
    else if (!decode_ok && !stall_c)  illegal_q <= 1'b1;
  end

  assign IllegalD = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand sequences for
// stall/illegal/reset corners, then random traffic against a reference model.
`timescale 1ns/1ps
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrD = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  A3_W = '0;
  logic [31:0] ResultW = '0;
  logic [1:0]  MEM_CtrlE = '0;
  logic [4:0]  A3E = '0;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  A3D;
  logic [2:0]  funct3D, ALUControlD;
  logic        RegWriteD, ALUSrcD, StallD, IllegalD;
  logic [1:0]  MEM_CtrlD;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .RegWriteW(RegWriteW), .A3_W(A3_W),
    .ResultW(ResultW), .MEM_CtrlE(MEM_CtrlE), .A3E(A3E), .RD1D(RD1D), .RD2D(RD2D),
    .A3D(A3D), .SignImmD(SignImmD), .funct3D(funct3D), .RegWriteD(RegWriteD),
    .ALUSrcD(ALUSrcD), .MEM_CtrlD(MEM_CtrlD), .ALUControlD(ALUControlD),
    .StallD(StallD), .IllegalD(IllegalD)
  );

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  a3;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        rw;
    logic        as;
    logic [1:0]  mem;
    logic [2:0]  alu;
    logic        st;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  a3w;
    logic [31:0] res;
    logic [1:0]  meme;
    logic [4:0]  a3e;
    obs_t        exp;
  } vec_t;

  function automatic obs_t mk(input logic [31:0] rd1, input logic [31:0] rd2, input logic [4:0] a3,
                              input logic [31:0] imm, input logic [2:0] f3, input logic rw,
                              input logic as, input logic [1:0] mem, input logic [2:0] alu,
                              input logic st);
    obs_t o;
    o.rd1 = rd1; o.rd2 = rd2; o.a3 = a3; o.imm = imm; o.f3 = f3;
    o.rw = rw; o.as = as; o.mem = mem; o.alu = alu; o.st = st;
    return o;
  endfunction

  function automatic string obs_str(input obs_t o);
    return $sformatf("rd1=%h rd2=%h a3=%0d imm=%h f3=%0d rw=%b as=%b mem=%b alu=%b st=%b",
                     o.rd1, o.rd2, o.a3, o.imm, o.f3, o.rw, o.as, o.mem, o.alu, o.st);
  endfunction

  function automatic obs_t sample();
    return mk(RD1D, RD2D, A3D, SignImmD, funct3D, RegWriteD, ALUSrcD, MEM_CtrlD, ALUControlD, StallD);
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {%s} expected {%s}", name, obs_str(act), obs_str(exp));
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_R, K_I, K_L, K_S, K_X} kind_e;
  logic [2:0]  alu_tab [8] = '{3'b000, 3'b110, 3'b101, 3'b000, 3'b100, 3'b111, 3'b011, 3'b010};
  logic [31:0] mrf [32];
  logic        mill;

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we, input logic [4:0] a3w,
                                        input logic [31:0] res);
    if (a == 0) return 32'h0;
    if (we && a3w == a) return res;
    return mrf[a];
  endfunction

  function automatic obs_t model_out(input logic [31:0] ins, input logic we, input logic [4:0] a3w,
                                     input logic [31:0] res, input logic [1:0] meme,
                                     input logic [4:0] a3e, input logic rst, output logic bad);
    obs_t  o;
    kind_e k;
    logic  legal, r1, r2, rw, as;
    logic [1:0] mem;
    logic [2:0] alu;
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    logic [4:0] rs1 = ins[19:15];
    logic [4:0] rs2 = ins[24:20];
    o = '0; bad = 1'b0;
    if (!rst) return o;
    case (ins[6:0])
      7'b0110011: k = K_R;
      7'b0010011: k = K_I;
      7'b0000011: k = K_L;
      7'b0100011: k = K_S;
      default:    k = K_X;
    endcase
    o.rd1 = mread(rs1, we, a3w, res);
    o.rd2 = mread(rs2, we, a3w, res);
    o.f3  = f3;
    r1 = (k != K_X); r2 = (k == K_R || k == K_S);
    rw = 1'b0; as = 1'b1; mem = 2'b00; alu = 3'b000; legal = 1'b0;
    case (k)
      K_R: begin
        o.a3 = ins[11:7]; rw = 1'b1; as = 1'b0;
        legal = (f3 != 3) && (f7 == 0 || (f7 == 7'h20 && f3 == 0));
        alu = (f7 == 7'h20) ? 3'b001 : alu_tab[f3];
      end
      K_I: begin
        o.a3 = ins[11:7]; o.imm = 32'($signed(ins[31:20])); rw = 1'b1;
        legal = (f3 != 3) && !((f3 == 1 || f3 == 5) && f7 != 0);
        alu = alu_tab[f3];
      end
      K_L: begin
        o.a3 = ins[11:7]; o.imm = 32'($signed(ins[31:20])); rw = 1'b1; mem = 2'b01;
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      K_S: begin
        o.imm = 32'($signed({ins[31:25], ins[11:7]})); mem = 2'b10;
        legal = (f3 <= 2);
      end
      default: legal = (ins == 0);
    endcase
    o.st = (meme == 2'b01) && (a3e != 0) && ((r1 && a3e == rs1) || (r2 && a3e == rs2));
    if (legal && !o.st) begin
      o.rw = rw; o.as = (k == K_X) ? 1'b0 : as; o.mem = mem; o.alu = (k == K_X) ? 3'b000 : alu;
    end
    bad = !legal && !o.st;
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    obs_t tmp;
    logic bad;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mrf[i] <= '0;
      mill <= 1'b0;
    end else begin
      if (RegWriteW && A3_W != 0) mrf[A3_W] <= ResultW;
      tmp = model_out(InstrD, RegWriteW, A3_W, ResultW, MEM_CtrlE, A3E, 1'b1, bad);
      if (bad) mill <= 1'b1;
    end
  end

  task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] a3w,
                       input logic [31:0] res, input logic [1:0] meme, input logic [4:0] a3e);
    InstrD = ins; RegWriteW = we; A3_W = a3w; ResultW = res; MEM_CtrlE = meme; A3E = a3e;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [12];

  initial begin
    obs_t e;
    logic bad;

    vecs[0]  = '{"add_x5",    32'h000280B3, 0, 0, 32'h0,        2'b00, 0, mk(32'hDEADBEEF, 0, 1, 0, 0, 1, 0, 2'b00, 3'b000, 0)};
    vecs[1]  = '{"bypass",    32'h000280B3, 1, 5, 32'h12345678, 2'b00, 0, mk(32'h12345678, 0, 1, 0, 0, 1, 0, 2'b00, 3'b000, 0)};
    vecs[2]  = '{"wr_x0",     32'h000280B3, 1, 0, 32'hFFFFFFFF, 2'b00, 0, mk(32'h12345678, 0, 1, 0, 0, 1, 0, 2'b00, 3'b000, 0)};
    vecs[3]  = '{"read_x0",   32'h00000033, 0, 0, 32'h0,        2'b00, 0, mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0)};
    vecs[4]  = '{"addi_m1",   32'hFFF00113, 1, 1, 32'h11111111, 2'b00, 0, mk(0, 0, 2, 32'hFFFFFFFF, 0, 1, 1, 2'b00, 3'b000, 0)};
    vecs[5]  = '{"sw_m4",     32'hFE20AE23, 1, 2, 32'h22222222, 2'b00, 0, mk(32'h11111111, 32'h22222222, 0, 32'hFFFFFFFC, 2, 0, 1, 2'b10, 3'b000, 0)};
    vecs[6]  = '{"lu_stall",  32'h002081B3, 0, 0, 32'h0,        2'b01, 2, mk(32'h11111111, 32'h22222222, 3, 0, 0, 0, 0, 2'b00, 3'b000, 1)};
    vecs[7]  = '{"lu_a3e0",   32'h002081B3, 0, 0, 32'h0,        2'b01, 0, mk(32'h11111111, 32'h22222222, 3, 0, 0, 1, 0, 2'b00, 3'b000, 0)};
    vecs[8]  = '{"lu_noload", 32'h002081B3, 0, 0, 32'h0,        2'b00, 2, mk(32'h11111111, 32'h22222222, 3, 0, 0, 1, 0, 2'b00, 3'b000, 0)};
    vecs[9]  = '{"sub",       32'h402081B3, 0, 0, 32'h0,        2'b00, 0, mk(32'h11111111, 32'h22222222, 3, 0, 0, 1, 0, 2'b00, 3'b001, 0)};
    vecs[10] = '{"lw_rs2_ign",32'h0080A203, 0, 0, 32'h0,        2'b01, 8, mk(32'h11111111, 0, 4, 8, 2, 1, 1, 2'b01, 3'b000, 0)};
    vecs[11] = '{"srli",      32'h0030D293, 0, 0, 32'h0,        2'b00, 0, mk(32'h11111111, 0, 5, 3, 5, 1, 1, 2'b00, 3'b111, 0)};

    // Reset holds every output at zero even with stall/bypass conditions present.
    drive(32'h002081B3, 1, 5, 32'hAAAA5555, 2'b01, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_obs("reset_outputs", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
    check_val("reset_illegal", 32'(IllegalD), 0);
    #1 rst_n = 1'b1;
    drive(32'h0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_val("zero_instr_illegal", 32'(IllegalD), 0);
    end
    @(negedge clk);
    check_obs("zero_instr_outputs", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
    drive(32'h0, 1, 5, 32'hDEADBEEF, 2'b00, 0);
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].we, vecs[i].a3w, vecs[i].res, vecs[i].meme, vecs[i].a3e);
      @(negedge clk);
      check_obs(vecs[i].name, vecs[i].exp);
      next_cycle();
    end
    check_val("no_illegal_after_table", 32'(IllegalD), 0);

    // Illegal funct under stall is not flagged until it issues.
    drive(32'h4020C1B3, 0, 0, 0, 2'b01, 1);
    @(negedge clk);
    check_val("stall_on_illegal", 32'(StallD), 1);
    next_cycle();
    check_val("illegal_held_by_stall", 32'(IllegalD), 0);
    MEM_CtrlE = 2'b00;
    @(negedge clk);
    check_val("illegal_ctrl_bubble", {RegWriteD, ALUSrcD, MEM_CtrlD, ALUControlD, StallD}, 0);
    next_cycle();
    check_val("illegal_after_issue", 32'(IllegalD), 1);

    // Asynchronous reset pulse between edges clears flag and registers.
    drive(32'h002081B3, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midreset_illegal", 32'(IllegalD), 0);
    #1 rst_n = 1'b1;
    #1;
    check_obs("midreset_regs", mk(0, 0, 3, 0, 0, 1, 0, 2'b00, 3'b000, 0));
    next_cycle();
    check_val("midreset_illegal_stays", 32'(IllegalD), 0);

    // All-ones word: bubble, then sticky flag.
    drive(32'hFFFFFFFF, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    check_val("ones_ctrl_bubble", {RegWriteD, ALUSrcD, MEM_CtrlD, ALUControlD, StallD}, 0);
    next_cycle();
    check_val("ones_illegal_set", 32'(IllegalD), 1);
    drive(32'h002081B3, 0, 0, 0, 2'b00, 0);
    repeat (2) next_cycle();
    check_val("illegal_sticky", 32'(IllegalD), 1);

    // Randomised traffic against the model, with a reset to reopen the flag.
    for (int n = 0; n < 600; n++) begin
      logic [6:0]  opc;
      logic [6:0]  f7;
      logic [31:0] ins;
      logic [4:0]  rs1, rs2, a3e, a3w;
      if (n == 300) begin
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      case ($urandom_range(0, 5))
        0: opc = 7'b0110011;
        1: opc = 7'b0010011;
        2: opc = 7'b0000011;
        3: opc = 7'b0100011;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 2: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      ins = {f7, rs2, rs1, 3'($urandom), 5'($urandom), opc};
      if ($urandom_range(0, 9) == 0) ins = 32'h0;
      a3e = ($urandom_range(0, 1) == 1) ? rs1 : (($urandom_range(0, 1) == 1) ? rs2 : 5'($urandom));
      a3w = ($urandom_range(0, 1) == 1) ? rs2 : 5'($urandom_range(0, 7));
      drive(ins, 1'($urandom), a3w, $urandom, 2'($urandom), a3e);
      @(negedge clk);
      e = model_out(InstrD, RegWriteW, A3_W, ResultW, MEM_CtrlE, A3E, rst_n, bad);
      check_obs($sformatf("rand%0d_%h", n, ins), e);
      check_val("rand_illegal", 32'(IllegalD), 32'(mill));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage pipeline. Sits between the IF/ID register and the ID/EX register, and feeds every `*D` input of ID/EX. It contains the 32×32 register file, with its write port driven by writeback, plus the main/ALU decoder, the immediate generator, load-use hazard detection and a sticky illegal-instruction flag.

## Interface
Parameters: none; all widths fixed by the RV32 subset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- InstrD  in  32  instruction from IF/ID
- RegWriteW  in  1  writeback write enable
- A3_W  in  5  writeback destination register
- ResultW  in  32  writeback data
- MEM_CtrlE  in  2  MEM_Ctrl of the instruction currently in EX (ID/EX output)
- A3E  in  5  destination register of the instruction in EX
- RD1D, RD2D  out  32  rs1/rs2 operand values
- A3D  out  5  destination register
- SignImmD  out  32  sign-extended immediate
- funct3D  out  3  InstrD[14:12]
- RegWriteD, ALUSrcD  out  1  control
- MEM_CtrlD  out  2  00 none, 01 load, 10 store
- ALUControlD  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
- StallD  out  1  load-use stall request to PC and IF/ID
- IllegalD  out  1  sticky illegal-instruction flag

## Operation
- **Opcode 0110011 (R-type):** RegWriteD=1, ALUSrcD=0, MEM_CtrlD=00, SignImmD=0.
  - ALU op by funct3: 000 gives ADD, or SUB when funct7=0100000. 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL.
  - funct7 must be 0000000, except for SUB. Any other funct7 or funct3/funct7 combination is illegal.
- **Opcode 0010011 (I-ALU):** same ALU mapping, but 000 is always ADD. ALUSrcD=1, RegWriteD=1. For 001/101, imm[11:5] must be 0, otherwise illegal.
- **Opcode 0000011 (load):** MEM_CtrlD=01, ALUSrcD=1, RegWriteD=1, ADD. funct3 must be in {000, 001, 010, 100, 101}.
- **Opcode 0100011 (store):** MEM_CtrlD=10, ALUSrcD=1, RegWriteD=0, ADD, A3D=0. funct3 must be in {000, 001, 010}.
- **Immediate:**
  - I-type/load: sign-extended InstrD[31:20].
  - Store: sign-extended {InstrD[31:25], InstrD[11:7]}.
- **A3D:** InstrD[11:7] for R/I/load.
- **Bubble:** all control outputs 0. This applies to any other opcode, to illegal funct fields, and to InstrD=32'h0.
  - 32'h0 is a legal bubble and never sets IllegalD.
- **Register file:**
  - Write at posedge clk when RegWriteW=1 and A3_W≠0. Writes to x0 are discarded.
  - Reads are combinational; x0 always reads 0.
  - Bypass: if RegWriteW=1, A3_W≠0 and A3_W equals the read address, the read returns ResultW in the same cycle.
- **Load-use hazard:** StallD=1 when all of the following hold:
  - MEM_CtrlE=01 and A3E≠0;
  - A3E equals rs1 (R/I/load/store), or A3E equals rs2 (R/store only).
  - While StallD=1, all control outputs are forced to 0 and RD/A3/imm pass through unchanged.
- **IllegalD:** set at the first posedge where the decode is illegal and StallD=0. Cleared only by rst_n.

## Timing
- All outputs except IllegalD are combinational from InstrD, register state and the WB/EX inputs: zero-cycle latency.
- A register written at edge N is visible on the array path from edge N; it is visible via the bypass already in the cycle before edge N.
- **Reset:** asynchronous. All 32 registers clear immediately and IllegalD=0.
  - While rst_n=0, every output is forced to 0, including StallD.
  - Reset asserted mid-write discards that write.
- **Simultaneous events:**
  - A WB write to the register that triggers a load-use stall does not cancel the stall.
  - An illegal instruction under stall does not set IllegalD until it decodes with StallD=0.

## Structure
- `riscv_pkg` holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE);
  - ALUControl encodings (ALU_ADD…ALU_SRL);
  - MEM_Ctrl encodings (MEM_NONE, MEM_LOAD, MEM_STORE).
- One sub-module, `reg_file`: 2R1W, 32×32, x0 hardwired, write-through bypass, asynchronous active-low clear.
- Decoder, immediate generator, hazard logic and the IllegalD flop live in `id_stage`.

## Test plan
- **Reset then register-file write:**
  - Reset, then WB writes x5=32'hDEADBEEF.
  - Next cycle InstrD=32'h000280B3 (add x1,x5,x0) → RD1D=32'hDEADBEEF, RD2D=0, ALUControlD=000, RegWriteD=1, A3D=1.
- **Bypass and x0:**
  - Same cycle RegWriteW=1, A3_W=5, ResultW=32'h12345678 with the same InstrD → RD1D=32'h12345678.
  - WB write x0=32'hFFFFFFFF → later reads of x0 return 0.
- **Immediates:**
  - InstrD=32'hFFF00113 (addi x2,x0,-1) → SignImmD=32'hFFFFFFFF, ALUSrcD=1, RegWriteD=1, A3D=2.
  - InstrD=32'hFE20AE23 (sw x2,-4(x1)) → SignImmD=32'hFFFFFFFC, MEM_CtrlD=10, RegWriteD=0, A3D=0.
- **Load-use:**
  - MEM_CtrlE=01, A3E=2, InstrD=32'h002081B3 (add x3,x1,x2) → StallD=1, all control 0.
  - Same with A3E=0 or MEM_CtrlE=00 → StallD=0, normal decode.
- **Illegal:**
  - InstrD=32'hFFFFFFFF → control 0; IllegalD=1 after next edge and remains 1 through later legal instructions.
  - InstrD=32'h0 from reset → IllegalD stays 0.
- **Mid-operation reset:**
  - Pulse rst_n low between edges with registers populated → RD1D/RD2D read 0 afterwards and IllegalD=0.
